// File: rtl/board_io_pkg.sv
// Shared board I/O definitions: button FSM encodings, 12 MHz timing defaults, counter sizing.
package board_io_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // 10 ms debounce and 1 s long-press at 12 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 120_000;
  localparam int unsigned DEF_LONG_CYCLES     = 12_000_000;

  // Width able to hold 0..max_val, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button front end: synchronise, debounce, and emit press/release/long-press events
// plus a press-toggled LED level.
module button_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic led_toggle
);

  localparam int unsigned DEB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W  = cnt_width(LONG_CYCLES);
  localparam bit          LONG_EN = (LONG_CYCLES > 0);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_EN ? LONG_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic sync_pin;
  logic pressed;

  sync_2ff #(
    .RESET_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_raw),
    .q_o   (sync_pin)
  );

  assign pressed = ACTIVE_LOW ? ~sync_pin : sync_pin;

  btn_state_e        state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              toggle_q, toggle_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RELEASED;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      toggle_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      toggle_q   <= toggle_d;
    end
  end

  // Next-state and registered-output logic; event pulses default low every cycle
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    toggle_d   = toggle_q;

    unique case (state_q)
      RELEASED: begin
        if (pressed) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = RELEASED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
          level_d    = 1'b1;
          press_d    = 1'b1;
          toggle_d   = ~toggle_q;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      PRESSED: begin
        // hold_cnt passes HOLD_LAST only once per press, so btn_long cannot repeat
        if (!pressed) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (LONG_EN && (hold_cnt_q == HOLD_LAST)) begin
            long_d = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = PRESSED;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign led_toggle  = toggle_q;

endmodule
